rk_irq_ctrl: RTL
================

// Module: rk_irq_ctrl
// PURPOSE
//  Parametrised edge-triggered interrupt controller for the RK2040 core.
//  Generalises the single hard-wired falling-edge interrupt on inputPort[5] to
//  N_CH channels, each with its own rising/falling/both-edge mode, enable and
//  overrun flag. Sits between inputPort and the core's interrupt entry.
//  Presents one prioritised request (lowest index wins) with a req/ack handshake.
// PARAMETERS
//  N_CH         24  number of interrupt channels (1..32), matches inputPort width
//  SYNC_STAGES  2   flip-flop synchroniser depth per channel (>=2)
//  ID_W         $clog2(N_CH) (min 1)  width of irq_id; derived, not overridden
// PORTS
//  clk       in   1      system clock, all logic on rising edge
//  rst       in   1      asynchronous active-low reset (0 = reset)
//  irq_in    in   N_CH   raw asynchronous interrupt sources (e.g. inputPort)
//  en        in   N_CH   per-channel enable; masks req, pending still captured
//  rise_en   in   N_CH   per-channel: capture rising edges
//  fall_en   in   N_CH   per-channel: capture falling edges
//  irq_ack   in   1      core acknowledge, single-cycle pulse
//  irq_req   out  1      request to core
//  irq_id    out  ID_W   index of channel being requested
//  pending   out  N_CH   captured, unserviced edges
//  overrun   out  N_CH   sticky: edge seen while channel already pending
// BEHAVIOUR
//  Reset (rst=0, async): syncs, prev-sample regs, pending, overrun = 0;
//   irq_req=0, irq_id=0, FSM=IDLE. Prev-sample regs load the synced value
//   on the first clock after release, so no spurious edges are captured.
//  Edge detect: s = synchroniser output, p = s delayed 1 cycle;
//   edge[i] = (rise_en[i] & s[i] & ~p[i]) | (fall_en[i] & ~s[i] & p[i]).
//   Both rise_en and fall_en = 1 gives both-edge mode; both 0 disables capture.
//  Latency: irq_in change first sampled at edge t0 -> pending[i]=1 after edge
//   t0+SYNC_STAGES -> irq_req=1 after edge t0+SYNC_STAGES+1 (FSM IDLE, highest
//   priority enabled channel).
//  pending[i] set on edge[i]. If already set, set overrun[i] (sticky).
//   Cleared only by ack of channel i.
//  FSM states IDLE, REQ, GAP:
//   IDLE: if |(pending & en) -> latch irq_id = lowest set index, go to REQ.
//   REQ : irq_req=1, irq_id frozen. Changes to en/pending do not retarget.
//         On irq_ack: clear pending[irq_id] and overrun[irq_id], go to GAP.
//   GAP : irq_req=0 for exactly one cycle, then go to IDLE. The core always
//         sees deassertion between requests.
//  irq_ack outside REQ is ignored. Ack held >1 cycle acts once.
//  Simultaneous ack and new edge on the same channel: edge wins. pending stays
//   1, overrun cleared. That channel is re-requested after GAP.
//  Disabling the requested channel while in REQ: request holds until ack.
//  Masked channels keep pending and overrun; enabling one later raises a req.
//  Reset asserted mid-request: all state cleared immediately; edge in flight
//   is lost.
// TESTING
//  1 single falling edge ch5, fall_en[5]=1, en[5]=1, SYNC=2 -> pending[5] 2 clk
//    after sample, irq_req=1 & irq_id=5 one clk later; ack -> req=0, pending=0
//  2 edges ch3 and ch9 same cycle -> id=3 first; ack -> 1 clk GAP req=0 ->
//    id=9; ack -> pending=0
//  3 two rising edges ch0 before ack -> overrun[0]=1, single request; ack clears
//    pending[0] and overrun[0]
//  4 both-edge ch7: pulse 0->1->0 -> two requests id=7; rise_en=fall_en=0 ->
//    no pending
//  5 en[2]=0, edge ch2 -> pending[2]=1, irq_req=0; set en[2]=1 -> req id=2
//  6 rst low during REQ -> irq_req, pending, overrun = 0 asynchronously;
//    stable-high input after release -> no spurious edge

Source files
------------

// File: rtl/rk_irq_ctrl.sv
// Edge-triggered interrupt controller: N_CH synchronised sources with per-channel
// rise/fall/both-edge capture, enable and sticky overrun; one prioritised req/ack request.
module rk_irq_ctrl #(
    parameter  int N_CH        = 24,
    parameter  int SYNC_STAGES = 2,
    localparam int ID_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] irq_in,
    input  logic [N_CH-1:0] en,
    input  logic [N_CH-1:0] rise_en,
    input  logic [N_CH-1:0] fall_en,
    input  logic            irq_ack,
    output logic            irq_req,
    output logic [ID_W-1:0] irq_id,
    output logic [N_CH-1:0] pending,
    output logic [N_CH-1:0] overrun
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
    logic [N_CH-1:0]                  prev_q;
    logic [SYNC_STAGES:0]             arm_q;
    logic [1:0]                       state;
    logic [N_CH-1:0]                  synced;
    logic [N_CH-1:0]                  edge_hit;
    logic [N_CH-1:0]                  clr;
    logic [N_CH-1:0]                  req_vec;
    logic [ID_W-1:0]                  first_id;
    logic                             armed;
    logic                             ack_fire;

    assign synced = sync_q[SYNC_STAGES-1];

    // Edge capture is held off until the synchroniser and prev-sample register
    // both hold real input values, so a source already high at reset release
    // never looks like a rising edge.
    assign armed    = arm_q[SYNC_STAGES];
    assign edge_hit = armed ? ((rise_en & synced & ~prev_q) | (fall_en & ~synced & prev_q))
                            : '0;

    assign ack_fire = (state == REQ) && irq_ack;
    assign clr      = ack_fire ? (N_CH'(1) << irq_id) : '0;
    assign req_vec  = pending & en;
    assign irq_req  = (state == REQ);

    always_comb begin
        first_id = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req_vec[i]) first_id = ID_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= '0;
            arm_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
            prev_q <= synced;
            arm_q  <= {arm_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // A new edge on the channel being acknowledged wins over the clear, but
    // its overrun flag is still cleared by the ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
            overrun <= '0;
        end else begin
            pending <= (pending & ~clr) | edge_hit;
            overrun <= (overrun | (edge_hit & pending)) & ~clr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            irq_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_vec) begin
                        irq_id <= first_id;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (irq_ack) state <= GAP;
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
